// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - RV32M multiply controller types, signedness and word-select helpers
package rv32m_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } mul_ctrl_state_t;

    // [1] multiplicand signed, [0] multiplier signed
    function automatic logic [1:0] op_to_signed(input mul_op_t op);
        case (op)
            MUL, MULH: return 2'b11;
            MULHSU:    return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] select_word(input mul_op_t op, input logic [63:0] product);
        return (op == MUL) ? product[31:0] : product[63:32];
    endfunction

endpackage

// File: rtl/rv32m_mul_ctrl_if.sv
// rtl/rv32m_mul_ctrl_if.sv - controller-to-multiplier bus (master = controller, slave = multiplier)
interface rv32m_mul_ctrl_if;

    logic        mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [1:0]  mul_is_signed;
    logic        mul_finished;
    logic [63:0] mul_product;

    modport master (
        output mul_start,
        output mul_multiplicand,
        output mul_multiplier,
        output mul_is_signed,
        input  mul_finished,
        input  mul_product
    );

    modport slave (
        input  mul_start,
        input  mul_multiplicand,
        input  mul_multiplier,
        input  mul_is_signed,
        output mul_finished,
        output mul_product
    );

endinterface

// File: rtl/rv32m_mul_fuse_cache.sv
// rtl/rv32m_mul_fuse_cache.sv - last operands/signedness/product store for back-to-back reuse (RV32M_MUL_FUSE_EN)
module rv32m_mul_fuse_cache
    import rv32m_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        clear,
    input  logic        store,
    input  logic [31:0] store_a,
    input  logic [31:0] store_b,
    input  logic [1:0]  store_signed,
    input  logic [63:0] store_product,
    input  logic [31:0] lookup_a,
    input  logic [31:0] lookup_b,
    input  mul_op_t     lookup_op,
    output logic        hit,
    output logic [63:0] product
);

    logic        valid_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  signed_q;
    logic [63:0] product_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= '0;
            product_q <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (store) begin
            valid_q   <= 1'b1;
            a_q       <= store_a;
            b_q       <= store_b;
            signed_q  <= store_signed;
            product_q <= store_product;
        end
    end

    // The low word is identical for every signedness, so MUL can reuse any stored product.
    assign hit = valid_q && (a_q == lookup_a) && (b_q == lookup_b) &&
                 ((lookup_op == MUL) || (signed_q == op_to_signed(lookup_op)));

    assign product = product_q;

endmodule

// File: rtl/rv32m_mul_ctrl.sv
// rtl/rv32m_mul_ctrl.sv - RV32M multiply issue/retire controller; RV32M_MUL_FUSE_EN enables product reuse
module rv32m_mul_ctrl
    import rv32m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             err,
    rv32m_mul_ctrl_if.master mul_if
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mul_ctrl_state_t  state_q;
    mul_ctrl_state_t  state_d;
    mul_op_t          op_in;
    mul_op_t          op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       sgn_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             start;
    logic             accept;
    logic             capture;
    logic             err_d;
    logic             fuse_hit;
    logic [63:0]      fuse_product;

    assign op_in = mul_op_t'(req_op);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = fuse_hit ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                busy    = 1'b1;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (mul_if.mul_finished) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are latched at acceptance so execute may change rs*/op while busy.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_q   <= MUL;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            result <= '0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                op_q  <= op_in;
                a_q   <= rs1_data;
                b_q   <= rs2_data;
                sgn_q <= op_to_signed(op_in);
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture) begin
                result <= select_word(op_q, mul_if.mul_product);
            end else if (accept && fuse_hit) begin
                result <= select_word(op_in, fuse_product);
            end
        end
    end

    assign err                     = err_q;
    assign mul_if.mul_start        = start;
    assign mul_if.mul_multiplicand = a_q;
    assign mul_if.mul_multiplier   = b_q;
    assign mul_if.mul_is_signed    = sgn_q;

`ifdef RV32M_MUL_FUSE_EN
    rv32m_mul_fuse_cache u_fuse_cache (
        .CLK           (CLK),
        .nRST          (nRST),
        .clear         (flush | err_d),
        .store         (capture),
        .store_a       (a_q),
        .store_b       (b_q),
        .store_signed  (sgn_q),
        .store_product (mul_if.mul_product),
        .lookup_a      (rs1_data),
        .lookup_b      (rs2_data),
        .lookup_op     (op_in),
        .hit           (fuse_hit),
        .product       (fuse_product)
    );
`else
    assign fuse_hit     = 1'b0;
    assign fuse_product = 64'd0;
`endif

endmodule

// File: tb/tb_rv32m_mul_ctrl.sv
// tb/tb_rv32m_mul_ctrl.sv - randomized self-checking bench for rv32m_mul_ctrl with a behavioural multiplier stub
module tb_rv32m_mul_ctrl;

    localparam int TIMEOUT = 8;
`ifdef RV32M_MUL_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    rv32m_mul_ctrl_if mif();

    rv32m_mul_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_op    (req_op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .mul_if    (mif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] op_sign(input logic [1:0] op);
        case (op)
            2'd0, 2'd1: return 2'b11;
            2'd2:       return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [63:0] mprod(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        longint x;
        longint y;
        x = s[1] ? longint'(signed'(a)) : longint'({32'd0, a});
        y = s[0] ? longint'(signed'(b)) : longint'({32'd0, b});
        return 64'(x * y);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Multiplier stub: lat cycles after a start it returns the product (0 = never finishes)
    int          stub_lat = 3;
    bit          stub_force = 1'b0;
    logic [63:0] stub_force_val = '0;
    int          stub_cnt = 0;
    logic [63:0] stub_prod = '0;

    always @(negedge CLK) begin
        mif.mul_finished = 1'b0;
        if (mif.mul_start) begin
            stub_cnt  = stub_lat;
            stub_prod = stub_force ? stub_force_val
                                   : mprod(mif.mul_multiplicand, mif.mul_multiplier, mif.mul_is_signed);
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                mif.mul_finished = 1'b1;
                mif.mul_product  = stub_prod;
            end
        end
    end

    // Reference state: last returned result and the reusable-product record
    logic [31:0] last_result = '0;
    bit          f_valid = 1'b0;
    logic [31:0] f_a = '0;
    logic [31:0] f_b = '0;
    logic [1:0]  f_sgn = '0;
    logic [63:0] f_prod = '0;

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit force_en, input logic [63:0] force_val);
        logic [63:0] prod;
        logic [31:0] exp_res;
        bit          hit;
        bit          exp_err;
        int          cyc;
        int          starts;
        int          done_cyc;
        int          err_cyc;
        int          busy_gaps;
        prod    = force_en ? force_val : mprod(a, b, op_sign(op));
        hit     = FUSE && f_valid && (a == f_a) && (b == f_b) && ((op == 2'd0) || (op_sign(op) == f_sgn));
        if (hit) prod = f_prod;
        exp_res = (op == 2'd0) ? prod[31:0] : prod[63:32];
        exp_err = !hit && (lat == 0);

        @(negedge CLK);
        stub_lat       = lat;
        stub_force     = force_en;
        stub_force_val = force_val;
        req_valid      = 1'b1;
        req_op         = op;
        rs1_data       = a;
        rs2_data       = b;
        cyc = 0; starts = 0; done_cyc = -1; err_cyc = -1; busy_gaps = 0;
        while (done_cyc < 0 && err_cyc < 0 && cyc < TIMEOUT + 20) begin
            @(negedge CLK);
            cyc++;
            if (mif.mul_start) begin
                starts++;
                if (starts == 1) begin
                    check_eq("issue_multiplicand", 64'(mif.mul_multiplicand), 64'(a));
                    check_eq("issue_multiplier", 64'(mif.mul_multiplier), 64'(b));
                    check_eq("issue_signed", 64'(mif.mul_is_signed), 64'(op_sign(op)));
                end
            end
            if (done) begin
                done_cyc = cyc;
                check_eq("done_busy_low", 64'(busy), 64'd0);
            end else if (err) begin
                err_cyc = cyc;
            end else if (!busy) begin
                busy_gaps++;
            end
            if (done || err) begin
                req_valid = 1'b0;
            end else begin
                rs1_data = 32'($urandom);
                rs2_data = 32'($urandom);
                req_op   = 2'($urandom);
            end
        end
        req_valid = 1'b0;

        check_eq("start_count", 64'(starts), hit ? 64'd0 : 64'd1);
        if (exp_err) begin
            check_eq("err_cycle", 64'(err_cyc), 64'(TIMEOUT + 2));
            check_eq("err_result_held", 64'(result), 64'(last_result));
            f_valid = 1'b0;
        end else begin
            check_eq("done_cycle", 64'(done_cyc), hit ? 64'd1 : 64'(lat + 2));
            check_eq("result", 64'(result), 64'(exp_res));
            last_result = exp_res;
            if (!hit) begin
                f_valid = 1'b1;
                f_a     = a;
                f_b     = b;
                f_sgn   = op_sign(op);
                f_prod  = prod;
            end
        end
        check_eq("busy_gaps", 64'(busy_gaps), 64'd0);
        @(negedge CLK);
        check_eq("post_idle", 64'({busy, done, err, mif.mul_start}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit          seen_d;
        bit          seen_e;
        bit          seen_s;
        bit          seen_b;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (2) @(negedge CLK);
        check_eq("reset_ctrl", 64'({busy, done, err, mif.mul_start}), 64'd0);
        check_eq("reset_result", 64'(result), 64'd0);
        check_eq("reset_bus", {mif.mul_multiplicand, mif.mul_multiplier}, 64'd0);
        check_eq("reset_signed", 64'(mif.mul_is_signed), 64'd0);
        nRST = 1'b1;

        run_op(2'd0, 32'd7, 32'd6, 3, 1'b1, 64'd42);
        check_eq("mul_7x6", 64'(result), 64'd42);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1, 64'd1);
        check_eq("mulh_m1", 64'(result), 64'h0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1, 64'hFFFF_FFFE_0000_0001);
        check_eq("mulhu_max", 64'(result), 64'hFFFF_FFFE);
        run_op(2'd2, 32'hFFFF_FFFF, 32'd2, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("mulhsu_m1x2", 64'(result), 64'hFFFF_FFFF);

        // MULH followed by MUL on identical operands: reuse candidate when fusion is built in
        run_op(2'd1, 32'hDEAD_0001, 32'h0BEE_0002, 2, 1'b1, 64'h1122_3344_5566_7788);
        run_op(2'd0, 32'hDEAD_0001, 32'h0BEE_0002, 3, 1'b1, 64'h1122_3344_5566_7788);
        check_eq("reuse_low_word", 64'(result), 64'h5566_7788);

        // flush in the second WAIT cycle, stale finished must be ignored
        @(negedge CLK);
        stub_lat = 4; stub_force = 1'b0;
        req_valid = 1'b1; req_op = 2'd0; rs1_data = 32'($urandom); rs2_data = 32'($urandom);
        repeat (3) @(negedge CLK);
        flush = 1'b1; req_valid = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        f_valid = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        seen_d = 0; seen_e = 0; seen_s = 0;
        repeat (6) begin
            @(negedge CLK);
            seen_d |= done; seen_e |= err; seen_s |= mif.mul_start;
        end
        check_eq("flush_quiet", 64'({seen_d, seen_e, seen_s}), 64'd0);
        run_op(2'd0, 32'd3, 32'd3, 3, 1'b0, 64'd0);
        check_eq("mul_3x3", 64'(result), 64'd9);

        // flush together with a request in IDLE is not accepted
        @(negedge CLK);
        req_valid = 1'b1; flush = 1'b1; rs1_data = 32'd5; rs2_data = 32'd5;
        seen_s = 0; seen_b = 0;
        repeat (3) begin
            @(negedge CLK);
            seen_s |= mif.mul_start; seen_b |= busy;
        end
        flush = 1'b0; req_valid = 1'b0;
        f_valid = 1'b0;
        check_eq("flush_idle_reject", 64'({seen_s, seen_b}), 64'd0);

        ra = pick(); rb = pick();
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || $urandom_range(0, 3) != 0) begin
                ra = pick();
                rb = pick();
            end
            run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(1, 5), 1'b0, 64'd0);
        end

        run_op(2'd3, 32'h0000_1234, 32'h0000_5678, 0, 1'b0, 64'd0);

        run_op(2'd0, 32'd7, 32'd6, 3, 1'b0, 64'd0);

        // asynchronous reset mid-operation
        @(negedge CLK);
        stub_lat = 3; stub_force = 1'b0;
        req_valid = 1'b1; req_op = 2'd1;
        rs1_data = 32'($urandom) | 32'd1; rs2_data = 32'($urandom) | 32'd1;
        repeat (2) @(negedge CLK);
        nRST = 1'b0; req_valid = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", 64'({busy, done, err, mif.mul_start}), 64'd0);
        check_eq("rst_mid_result", 64'(result), 64'd0);
        check_eq("rst_mid_bus", {mif.mul_multiplicand, mif.mul_multiplier}, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        last_result = '0;
        f_valid = 1'b0;
        seen_d = 0; seen_e = 0; seen_s = 0;
        repeat (6) begin
            @(negedge CLK);
            seen_d |= done; seen_e |= err; seen_s |= mif.mul_start;
        end
        check_eq("rst_mid_quiet", 64'({seen_d, seen_e, seen_s}), 64'd0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
